photo_downscaler: RTL

PHOTO_DOWNSCALER -- requirements
Module: photo_downscaler

---
 rtl/photo_downscaler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/photo_downscaler.sv
// Collapses a 320x240 thresholded photo into 40x30 cells: one cell per 8x8 block,
// set when the block holds at least BLOCK_THRESH black pixels. Optional macro: PHOTO_DOWNSCALER_STATS_EN.
module photo_downscaler #(
    parameter int BLOCK_THRESH = 32,
    parameter int FRAME_ROWS   = 240
) (
    input  logic         clk_in,
    input  logic         reset_n_in,
    input  logic         start_in,
    input  logic         row_valid_in,
    input  logic [319:0] row_in,
    output logic         row_valid_out,
    output logic [39:0]  row_out,
    output logic [4:0]   row_idx_out,
    output logic         busy_out,
`ifdef PHOTO_DOWNSCALER_STATS_EN
    output logic         done_out,
    output logic [10:0]  black_cells_out
`else
    output logic         done_out
`endif
);

    localparam int          NBLK     = 40;
    localparam logic [7:0]  THRESH_L = 8'(BLOCK_THRESH);
    localparam logic [7:0]  LAST_ROW = 8'(FRAME_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [7:0]  row_cnt_q;
    logic [2:0]  sub_q;
    logic [6:0]  acc_q [NBLK];
    logic [39:0] row_out_q;
    logic        row_valid_q;
    logic [4:0]  row_idx_q;
    logic        done_q, done_d;

    logic [3:0]  pc   [NBLK];
    logic [7:0]  sum  [NBLK];
    logic [39:0] cell_bits;
    logic        start_go;
    logic        accept;
    logic        emit;

    // Reset releases asynchronously-asserted but is only trusted once two clean edges have passed.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) sync_q <= 2'b00;
        else             sync_q <= {sync_q[0], 1'b1};
    end

    assign start_go = start_in && sync_q[1];
    assign accept   = (state_q == S_ACCUM) && row_valid_in && !start_in;
    assign emit     = accept && (sub_q == 3'd7);

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_block
            assign pc[gi]        = popcount8(row_in[8*gi +: 8]);
            assign sum[gi]       = {1'b0, acc_q[gi]} + {4'b0000, pc[gi]};
            assign cell_bits[gi] = (sum[gi] >= THRESH_L);
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_go) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (start_go)                              state_d = S_ACCUM;
                else if (accept && (row_cnt_q == LAST_ROW)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (start_go) begin
                    state_d = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            row_cnt_q   <= '0;
            sub_q       <= '0;
            row_out_q   <= '0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < NBLK; i++) acc_q[i] <= '0;
        end else begin
            row_valid_q <= emit;
            done_q      <= done_d;
            if (start_go) begin
                row_cnt_q <= '0;
                sub_q     <= '0;
                for (int i = 0; i < NBLK; i++) acc_q[i] <= '0;
            end else if (accept) begin
                row_cnt_q <= row_cnt_q + 8'd1;
                sub_q     <= sub_q + 3'd1;
                // The eighth row of a block folds straight into the decision, so the sum never exceeds 64.
                for (int i = 0; i < NBLK; i++) acc_q[i] <= emit ? 7'd0 : sum[i][6:0];
            end
            if (emit) begin
                row_out_q <= cell_bits;
                row_idx_q <= row_cnt_q[7:3];
            end
        end
    end

    assign row_valid_out = row_valid_q;
    assign row_out       = row_out_q;
    assign row_idx_out   = row_idx_q;
    assign busy_out      = (state_q == S_ACCUM);
    assign done_out      = done_q;

`ifdef PHOTO_DOWNSCALER_STATS_EN
    logic [10:0] black_q;
    logic [5:0]  emit_ones;

    always_comb begin
        emit_ones = '0;
        for (int i = 0; i < NBLK; i++) emit_ones = emit_ones + {5'b00000, cell_bits[i]};
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in)   black_q <= '0;
        else if (start_go) black_q <= '0;
        else if (emit)     black_q <= black_q + {5'b00000, emit_ones};
    end

    assign black_cells_out = black_q;
`endif

endmodule
